// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ clients.
// Latches the winning word, pulses TX_START/GNT, then follows TX_BUSY until the frame ends.
module uart_tx_arbiter #(
    parameter  int DATA_WIDTH  = 4,
    parameter  int NUM_REQ     = 4,
    parameter  int ACK_TIMEOUT = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic                          TX_BUSY,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [ID_W-1:0]               GNT_ID,
    output logic                          TX_START,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          ARB_BUSY,
    output logic                          TIMEOUT_ERR
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam int IW1   = ID_W + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACCEPT, WAIT_DONE} state_t;

    state_t          state_reg;
    logic [ID_W-1:0] ptr_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];
    logic                  pick_valid;
    logic [ID_W-1:0]       pick_id;
    logic [ID_W:0]         cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
            assign req_words[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First asserted request at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_reg} + IW1'(off);
            if (cand >= IW1'(NUM_REQ)) begin
                cand = cand - IW1'(NUM_REQ);
            end
            if (!pick_valid && REQ[cand[ID_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = cand[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            GNT         <= '0;
            GNT_ID      <= '0;
            TX_START    <= 1'b0;
            TX_DATA     <= '0;
            ARB_BUSY    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            GNT         <= '0;
            TX_START    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        TX_DATA   <= req_words[pick_id];
                        GNT_ID    <= pick_id;
                        GNT       <= NUM_REQ'(1) << pick_id;
                        TX_START  <= 1'b1;
                        ARB_BUSY  <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    ptr_reg   <= (GNT_ID == ID_W'(NUM_REQ - 1)) ? '0 : GNT_ID + 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    // The launch cycle counts toward the window, so the last wait cycle holds ACK_TIMEOUT-2.
                    if (TX_BUSY) begin
                        state_reg <= WAIT_DONE;
                    end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 2)) begin
                        TIMEOUT_ERR <= 1'b1;
                        ARB_BUSY    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!TX_BUSY) begin
                        ARB_BUSY  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    ARB_BUSY  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

    localparam int DW = 4;
    localparam int N  = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic          tx_busy;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          arb_busy;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: an active frame is described by its age (cycles since TX_START) and whether it was accepted.
    bit m_active, m_accepted;
    int m_age, m_ptr;
    logic [N-1:0]  e_gnt;
    logic [1:0]    e_gnt_id;
    logic          e_tx_start;
    logic [DW-1:0] e_tx_data;
    logic          e_arb_busy, e_timeout;

    int tx_wait, tx_left;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .REQ(req), .REQ_DATA(req_data), .TX_BUSY(tx_busy),
        .GNT(gnt), .GNT_ID(gnt_id), .TX_START(tx_start), .TX_DATA(tx_data),
        .ARB_BUSY(arb_busy), .TIMEOUT_ERR(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_accepted = 0; m_age = 0; m_ptr = 0;
        e_gnt = '0; e_gnt_id = '0; e_tx_start = 0; e_tx_data = '0;
        e_arb_busy = 0; e_timeout = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit to;
        int w;
        to = 0;
        w = -1;
        if (!m_active) begin
            if (req != 0) begin
                for (int off = 0; off < N; off++) begin
                    if (w < 0 && req[(m_ptr + off) % N]) w = (m_ptr + off) % N;
                end
                m_active = 1; m_age = 0; m_accepted = 0;
                e_gnt_id = w[1:0];
                e_tx_data = req_data[w*DW +: DW];
                m_ptr = (w + 1) % N;
            end
        end else begin
            if (m_age > 0) begin
                if (!m_accepted) begin
                    if (tx_busy) m_accepted = 1;
                    else if (m_age == TO - 1) begin
                        m_active = 0;
                        to = 1;
                    end
                end else if (!tx_busy) begin
                    m_active = 0;
                end
            end
            m_age++;
        end
        e_tx_start = m_active && (m_age == 0);
        e_gnt      = e_tx_start ? (N'(1) << e_gnt_id) : '0;
        e_arb_busy = m_active;
        e_timeout  = to;
    endtask

    task automatic compare_all();
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("gnt_id", 32'(gnt_id), 32'(e_gnt_id));
        check("tx_start", 32'(tx_start), 32'(e_tx_start));
        check("tx_data", 32'(tx_data), 32'(e_tx_data));
        check("arb_busy", 32'(arb_busy), 32'(e_arb_busy));
        check("timeout_err", 32'(timeout_err), 32'(e_timeout));
        if (e_tx_start) $display("launch id=%0d data=%h t=%0t", e_gnt_id, e_tx_data, $time);
        if (e_timeout)  $display("timeout id=%0d t=%0t", e_gnt_id, $time);
    endtask

    // Called at a falling edge with inputs set for the next rising edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_launch();
        int n;
        n = 0;
        while (!e_tx_start && n < 20) begin
            tick();
            n++;
        end
        check("launch_seen", 32'(tx_start), 32'd1);
    endtask

    task automatic frame(input int blen, input logic [N-1:0] req_after,
                         output int gid, output logic [DW-1:0] gdat, output logic [N-1:0] g);
        int n;
        tx_busy = 0;
        wait_launch();
        gid = int'(gnt_id); gdat = tx_data; g = gnt;
        req = req_after;
        tx_busy = 1;
        repeat (blen) tick();
        tx_busy = 0;
        n = 0;
        while (e_arb_busy && n < 5) begin
            tick();
            n++;
        end
        check("busy_release_latency", 32'(n), 32'd1);
        check("frame_end_arb_busy", 32'(arb_busy), 32'd0);
    endtask

    task automatic async_reset();
        rst = 1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        model_reset();
        req = 0; tx_busy = 0;
        @(negedge clk);
        compare_all();
        rst = 0;
    endtask

    initial begin
        int gid, n;
        logic [DW-1:0] gd;
        logic [N-1:0] g;
        bit seen;
        int order [5];
        logic [DW-1:0] dexp [5];
        order = '{0, 1, 2, 3, 0};
        dexp  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};

        rst = 1; req = 0; req_data = 0; tx_busy = 0;
        tx_wait = 0; tx_left = 0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 0;

        // Single requester
        req = 4'b0100; req_data = 16'h0A00;
        frame(10, 4'b0000, gid, gd, g);
        check("single_gnt", 32'(g), 32'h4);
        check("single_id", 32'(gid), 32'd2);
        check("single_data", 32'(gd), 32'hA);

        // Wrap fairness: pointer sits at 3
        req = 4'b1001; req_data = 16'h5006;
        frame(3, 4'b0001, gid, gd, g);
        check("wrap_first", 32'(gid), 32'd3);
        frame(3, 4'b0000, gid, gd, g);
        check("wrap_second", 32'(gid), 32'd0);

        // Timeout with TX_BUSY stuck low
        req = 4'b0010; req_data = 16'h0070;
        tx_busy = 0;
        wait_launch();
        req = 0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (timeout_err) break;
        end
        check("timeout_distance", 32'(n), 32'd16);
        check("timeout_arb_busy", 32'(arb_busy), 32'd0);
        req = 4'b0100; req_data = 16'h0900;
        frame(4, 4'b0000, gid, gd, g);
        check("after_timeout_id", 32'(gid), 32'd2);
        check("after_timeout_data", 32'(gd), 32'h9);

        // Withdrawn request during WAIT_DONE
        req = 4'b1000; req_data = 16'h3000;
        wait_launch();
        req = 0; tx_busy = 1;
        repeat (3) tick();
        req = 4'b0001;
        tick();
        req = 0;
        seen = 0;
        repeat (3) begin
            tick();
            seen |= gnt[0] | timeout_err;
        end
        tx_busy = 0;
        repeat (6) begin
            tick();
            seen |= gnt[0] | timeout_err;
        end
        check("withdrawn_no_grant", 32'(seen), 32'd0);

        // Reset in the middle of a frame
        req = 4'b0001; req_data = 16'h0004;
        wait_launch();
        req = 0; tx_busy = 1;
        repeat (3) tick();
        async_reset();
        req = 4'b0010; req_data = 16'h00E0;
        frame(4, 4'b0000, gid, gd, g);
        check("post_reset_gnt", 32'(g), 32'h2);
        check("post_reset_data", 32'(gd), 32'hE);

        // Everyone requesting continuously from a fresh pointer
        async_reset();
        req = 4'b1111; req_data = 16'hDCBA;
        for (int k = 0; k < 5; k++) begin
            frame(5, 4'b1111, gid, gd, g);
            check("rr_order", 32'(gid), 32'(order[k]));
            check("rr_data", 32'(gd), 32'(dexp[k]));
        end
        req = 0;

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (e_tx_start) begin
                if ($urandom_range(0, 5) == 0) begin
                    tx_wait = 0; tx_left = 0;
                end else begin
                    tx_wait = $urandom_range(0, 2);
                    tx_left = $urandom_range(1, 6);
                end
            end
            if (tx_wait > 0) begin
                tx_busy = 0;
                tx_wait--;
            end else if (tx_left > 0) begin
                tx_busy = 1;
                tx_left--;
            end else begin
                tx_busy = (!e_arb_busy && $urandom_range(0, 19) == 0);
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (e_tx_start && int'(e_gnt_id) == i) begin
                        if ($urandom_range(0, 1) == 1) req_data[i*DW +: DW] = DW'($urandom);
                        else req[i] = 0;
                    end else if ($urandom_range(0, 63) == 0) begin
                        req[i] = 0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    req[i] = 1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter datapath among NUM_REQ requesters. It accepts a parallel word from one requester at a time and launches it into the transmitter with a single-cycle start pulse. It then tracks the transmitter's busy flag until the frame completes before granting the next requester. It sits between the client blocks and the TX serializer, the transmit-side counterpart to the RX control unit.

## Interface
Parameters:
- DATA_WIDTH, 4, width of one UART data word
- NUM_REQ, 4, number of requesters (2..8)
- ACK_TIMEOUT, 16, max cycles to wait for TX_BUSY to rise after TX_START (≥2)
- ID_W, $clog2(NUM_REQ), width of GNT_ID (derived, not overridden)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- REQ  in  NUM_REQ  request per requester, level, held until granted
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- TX_BUSY  in  1  transmitter busy flag, high for the duration of a frame
- GNT  out  NUM_REQ  one-hot one-cycle grant/acknowledge pulse
- GNT_ID  out  ID_W  index of last granted requester, held until next grant
- TX_START  out  1  one-cycle launch pulse to transmitter
- TX_DATA  out  DATA_WIDTH  latched word, stable from LAUNCH until next grant
- ARB_BUSY  out  1  high whenever state ≠ IDLE
- TIMEOUT_ERR  out  1  one-cycle pulse when transmitter failed to accept

## Operation
- All outputs registered. Reset values: GNT=0, GNT_ID=0, TX_START=0, TX_DATA=0, ARB_BUSY=0, TIMEOUT_ERR=0, state=IDLE, pointer=0, timeout counter=0.
- States: IDLE, LAUNCH, WAIT_ACCEPT, WAIT_DONE.
- IDLE: if REQ≠0, choose first asserted requester searching upward from pointer with wrap (pointer, pointer+1, …, NUM_REQ-1, 0, …). Latch its REQ_DATA into TX_DATA, set GNT_ID, go LAUNCH. If REQ=0, stay.
- LAUNCH (exactly 1 cycle): GNT[GNT_ID]=1, TX_START=1. Pointer updated to (GNT_ID+1) mod NUM_REQ. Clear timeout counter. Go WAIT_ACCEPT.
- WAIT_ACCEPT: if TX_BUSY=1, go WAIT_DONE. Else increment counter. When counter reaches ACK_TIMEOUT-1 with TX_BUSY still 0, pulse TIMEOUT_ERR in the following cycle and go IDLE; the word is dropped, not retried.
- WAIT_DONE: stay while TX_BUSY=1; on TX_BUSY=0 go IDLE.
- Requester handshake: keep REQ and data stable until GNT seen. REQ still high in the cycle after GNT counts as a new request, served in round-robin order.
- REQ deasserted before grant: request withdrawn, no error.
- REQ_DATA of non-granted requesters is ignored.
- Reset mid-operation: state to IDLE immediately, pointer to 0, any pulse cleared. Transmitter-side recovery is the transmitter's concern.

## Timing
- REQ sampled in IDLE at edge k: GNT and TX_START high in cycle k+1 (1-cycle latency), both low in k+2.
- TX_BUSY high in the first WAIT_ACCEPT cycle: WAIT_DONE from the next edge.
- TX_BUSY falls at edge m: IDLE in cycle m+1. A pending REQ yields the next GNT/TX_START in cycle m+2.
- Minimum spacing between consecutive TX_START pulses is 4 cycles.
- Timeout: TX_START in cycle k+1 with TX_BUSY never rising gives TIMEOUT_ERR in cycle k+1+ACK_TIMEOUT and IDLE in the same cycle.
- TX_BUSY high while in IDLE (foreign/stale frame): ignored; arbitration proceeds.

## Test plan
- Single requester: REQ=4'b0100, data 0xA -> GNT=4'b0100 and TX_START 1 cycle later, TX_DATA=0xA, GNT_ID=2; busy held 10 cycles -> ARB_BUSY falls 1 cycle after TX_BUSY falls.
- All request continuously: REQ=4'b1111, TX model busy 5 cycles per frame -> grant order 0,1,2,3,0; each requester's data appears on TX_DATA once per round.
- Wrap fairness: pointer at 3 after grant to 2; REQ=4'b1001 -> grant 3 first, then 0.
- Timeout: TX_BUSY tied 0, ACK_TIMEOUT=16 -> TIMEOUT_ERR pulse exactly 16 cycles after TX_START, ARB_BUSY low the same cycle; a subsequent REQ is still served.
- Reset mid-frame: assert rst during WAIT_DONE -> all outputs 0 asynchronously; after release, REQ=4'b0010 -> GNT=4'b0010 (pointer restarted at 0).
- Withdrawn request: REQ=4'b0001 for one cycle while in WAIT_DONE, then low -> no GNT for requester 0 and no TIMEOUT_ERR.
